// File: rtl/rib_arbiter.sv
// rib_arbiter: registered four-master arbiter for the RIB bus.
// Fixed priority, fetch starvation guard, slave timeout.
module rib_arbiter #(
  parameter int TIMEOUT_CYC = 256,
  parameter int STARVE_MAX  = 8,
  parameter int CNT_W       = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic       slv_ready_i,
  output logic [3:0] grant_o,
  output logic       busy_o,
  output logic       hold_flag_o,
  output logic       timeout_o,
  output logic [1:0] err_master_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             timeout_q, timeout_d;
  logic [1:0]       err_q, err_d;
  logic [3:0]       win;
  logic [1:0]       g_idx;
  logic             arb;

  always_comb begin
    win = 4'b0000;
    if (req_i[1] && starve_q == STARVE_TOP) win = 4'b0010;
    else if (req_i[3]) win = 4'b1000;
    else if (req_i[2]) win = 4'b0100;
    else if (req_i[0]) win = 4'b0001;
    else if (req_i[1]) win = 4'b0010;
  end

  always_comb begin
    g_idx = 2'd0;
    unique case (1'b1)
      grant_q[3]: g_idx = 2'd3;
      grant_q[2]: g_idx = 2'd2;
      grant_q[1]: g_idx = 2'd1;
      default:    g_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    starve_d  = starve_q;
    timeout_d = 1'b0;
    err_d     = err_q;
    arb       = 1'b0;
    if (state_q == IDLE) begin
      grant_d = win;
      cnt_d   = '0;
      if (|req_i) begin
        state_d = BUSY;
        arb     = 1'b1;
      end
    end else begin
      if (!(|(req_i & grant_q))) begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end else if (slv_ready_i) begin
        // owner still requests, so a winner always exists here
        arb     = 1'b1;
        grant_d = win;
        cnt_d   = '0;
      end else if (cnt_q == CNT_TOP) begin
        timeout_d = 1'b1;
        err_d     = g_idx;
        grant_d   = '0;
        state_d   = IDLE;
        cnt_d     = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (arb && req_i[1]) begin
      if (win[1]) starve_d = '0;
      else if (starve_q != STARVE_TOP) starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      cnt_q     <= '0;
      starve_q  <= '0;
      timeout_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
      starve_q  <= starve_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
    end
  end

  assign grant_o      = grant_q;
  assign busy_o       = (state_q == BUSY);
  assign timeout_o    = timeout_q;
  assign err_master_o = err_q;
  assign hold_flag_o  = (req_i[0] & ~grant_q[0])
                      | (req_i[1] & ~grant_q[1] & busy_o);

endmodule
